// File: rtl/fifo_push_arb_pkg.sv
// Shared definitions for the FIFO push arbiter: FSM state encoding and the
// default data width of the requester and FIFO write ports.
package fifo_push_arb_pkg;

    localparam int FIFO_ARB_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fifo_push_arb.sv
// Shares the byte FIFO push port between two level req/ack producers.
// Define FIFO_ARB_PRIO_EN for fixed priority (requester 0 always wins); default is round robin.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting for a request while the FIFO is not full; grant here
//   PUSH    | o_push high for one cycle with latched data, winner acked
//   GAP     | o_push low so the FIFO edge detector re-arms before next write
module fifo_push_arb
    import fifo_push_arb_pkg::*;
#(
    parameter int DW = FIFO_ARB_DW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req0,
    input  logic [DW-1:0] i_dat0,
    output logic          o_ack0,
    input  logic          i_req1,
    input  logic [DW-1:0] i_dat1,
    output logic          o_ack1,
    input  logic          i_full,
    output logic          o_push,
    output logic [DW-1:0] o_dat,
    output logic          o_busy
);

    arb_state_e    state_q, state_d;
    logic          push_q, push_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          any_req;
    logic          grant1;

`ifdef FIFO_ARB_PRIO_EN
    assign grant1 = ~i_req0;
`else
    logic          last_grant_q, last_grant_d;

    // Under contention the requester that did not win last time is served.
    assign grant1 = (i_req0 & i_req1) ? ~last_grant_q : i_req1;
`endif

    assign any_req = i_req0 | i_req1;

    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        dat_d   = dat_q;
`ifndef FIFO_ARB_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!i_full && any_req) begin
                    state_d = ST_PUSH;
                    push_d  = 1'b1;
                    ack0_d  = ~grant1;
                    ack1_d  = grant1;
                    dat_d   = grant1 ? i_dat1 : i_dat0;
`ifndef FIFO_ARB_PRIO_EN
                    last_grant_d = grant1;
`endif
                end
            end
            ST_PUSH: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            push_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            dat_q   <= '0;
`ifndef FIFO_ARB_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            dat_q   <= dat_d;
`ifndef FIFO_ARB_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign o_push = push_q;
    assign o_ack0 = ack0_q;
    assign o_ack1 = ack1_q;
    assign o_busy = busy_q;
    assign o_dat  = dat_q;

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb: a 4-entry FIFO model on the push side
// and a timing-level reference model of the arbiter's grant schedule.
module tb_fifo_push_arb;

    localparam int DW = 8;

    logic          i_clk   = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_req0  = 1'b0;
    logic [DW-1:0] i_dat0  = '0;
    logic          i_req1  = 1'b0;
    logic [DW-1:0] i_dat1  = '0;
    logic          o_ack0, o_ack1, o_push, o_busy;
    logic [DW-1:0] o_dat;
    logic          i_full;
    logic          pop = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_push_arb #(.DW(DW)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_req0 (i_req0),
        .i_dat0 (i_dat0),
        .o_ack0 (o_ack0),
        .i_req1 (i_req1),
        .i_dat1 (i_dat1),
        .o_ack1 (o_ack1),
        .i_full (i_full),
        .o_push (o_push),
        .o_dat  (o_dat),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // FIFO: writes on a 0->1 edge of o_push, full at 4 entries
    logic [DW-1:0] fq[$];
    logic [DW-1:0] wr_log[$];
    logic          push_prev = 1'b0;
    logic          full_r    = 1'b0;
    bit            fifo_was_full;

    always @(posedge i_clk) begin
        if (i_reset) begin
            fq.delete();
            push_prev <= 1'b0;
            full_r    <= 1'b0;
        end else begin
            fifo_was_full = (fq.size() == 4);
            if (pop && fq.size() > 0) void'(fq.pop_front());
            if (o_push && !push_prev && !fifo_was_full) begin
                fq.push_back(o_dat);
                wr_log.push_back(o_dat);
            end
            push_prev <= o_push;
            full_r    <= (fq.size() == 4);
        end
    end
    assign i_full = full_r;

    // Reference: a grant decided in cycle d pushes in d+1; next decision no earlier than d+3
    int            cyc_n     = 0;
    int            ready_cyc = 0;
    int            push_cyc  = -100;
    logic          m_last    = 1'b1;
    logic          m_win     = 1'b0;
    logic [DW-1:0] m_dat     = '0;
    logic [DW-1:0] mlog[$];
    logic          exp_push = 1'b0, exp_ack0 = 1'b0, exp_ack1 = 1'b0, exp_busy = 1'b0;
    logic [DW-1:0] exp_dat  = '0;

    always @(posedge i_clk) begin
        cyc_n = cyc_n + 1;
        if (i_reset) begin
            ready_cyc = cyc_n;
            push_cyc  = -100;
            m_last    = 1'b1;
            m_dat     = '0;
        end else if ((cyc_n - 1) >= ready_cyc && !i_full && (i_req0 || i_req1)) begin
`ifdef FIFO_ARB_PRIO_EN
            m_win = !i_req0;
`else
            m_win = (i_req0 && i_req1) ? !m_last : i_req1;
`endif
            m_last    = m_win;
            m_dat     = m_win ? i_dat1 : i_dat0;
            push_cyc  = cyc_n;
            ready_cyc = cyc_n + 2;
            mlog.push_back(m_dat);
        end
        exp_push = (cyc_n == push_cyc);
        exp_ack0 = exp_push && !m_win;
        exp_ack1 = exp_push && m_win;
        exp_busy = (cyc_n == push_cyc) || (cyc_n == push_cyc + 1);
        exp_dat  = m_dat;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        pop    = 1'b1;
        repeat (6) tick();
        pop    = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_push, o_ack0, o_ack1, o_busy, o_dat} !== {4'b0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs got push=%b ack0=%b ack1=%b busy=%b dat=%h want all zero",
                     o_push, o_ack0, o_ack1, o_busy, o_dat);
        end
        checks++;
        if (fq.size() != 0 || i_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo got size=%0d full=%b want 0 0", fq.size(), i_full);
        end
        i_reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        wr_log.delete();
        i_req0 = 1'b1;
        i_dat0 = 8'h41;
        tick();
        checks++;
        if ({o_push, o_ack0, o_ack1, o_busy, o_dat} !== {4'b1101, 8'h41}) begin
            errors++;
            $display("FAIL single_push got push=%b ack0=%b ack1=%b busy=%b dat=%h want 1 1 0 1 41",
                     o_push, o_ack0, o_ack1, o_busy, o_dat);
        end
        i_dat0 = 8'h42;
        tick();
        checks++;
        if ({o_push, o_ack0, o_busy} !== 3'b001) begin
            errors++;
            $display("FAIL single_gap got push=%b ack0=%b busy=%b want 0 0 1", o_push, o_ack0, o_busy);
        end
        checks++;
        if (fq.size() != 1 || fq[0] !== 8'h41) begin
            errors++;
            $display("FAIL single_fifo got size=%0d head=%h want 1 41", fq.size(), (fq.size() > 0) ? fq[0] : 8'hxx);
        end
        tick();
        checks++;
        if ({o_push, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got push=%b busy=%b want 0 0", o_push, o_busy);
        end
        tick();
        checks++;
        if ({o_push, o_ack0, o_dat} !== {2'b11, 8'h42}) begin
            errors++;
            $display("FAIL single_second got push=%b ack0=%b dat=%h want 1 1 42", o_push, o_ack0, o_dat);
        end
        i_req0 = 1'b0;
        drain();
    endtask

    task automatic test_round_robin();
        logic          got_ack[$];
        logic          want_ack[4];
        logic [DW-1:0] want_dat[4];
        int            n;
        bit            seen;
`ifdef FIFO_ARB_PRIO_EN
        want_ack = '{1'b0, 1'b0, 1'b0, 1'b0};
        want_dat = '{8'h11, 8'h11, 8'h11, 8'h11};
`else
        want_ack = '{1'b0, 1'b1, 1'b0, 1'b1};
        want_dat = '{8'h11, 8'h22, 8'h11, 8'h22};
`endif
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        wr_log.delete();
        mlog.delete();
        i_req0 = 1'b1; i_dat0 = 8'h11;
        i_req1 = 1'b1; i_dat1 = 8'h22;
        pop    = 1'b1;
        for (int c = 0; c < 40 && got_ack.size() < 4; c++) begin
            tick();
            checks++;
            if ({o_push, o_ack0, o_ack1, o_busy, o_dat} !== {exp_push, exp_ack0, exp_ack1, exp_busy, exp_dat}) begin
                errors++;
                $display("FAIL rr_model t=%0t got push=%b ack=%b%b busy=%b dat=%h want %b %b%b %b %h", $time,
                         o_push, o_ack0, o_ack1, o_busy, o_dat, exp_push, exp_ack0, exp_ack1, exp_busy, exp_dat);
            end
            if (o_ack0) got_ack.push_back(1'b0);
            if (o_ack1) got_ack.push_back(1'b1);
        end
        i_req0 = 1'b0;
        tick();
        checks++;
        if (got_ack.size() != 4 || wr_log.size() < 4) begin
            errors++;
            $display("FAIL rr_count got acks=%0d writes=%0d want 4 4", got_ack.size(), wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_ack[i] !== want_ack[i] || wr_log[i] !== want_dat[i]) begin
                    errors++;
                    $display("FAIL rr_order idx=%0d got ack%0d dat=%h want ack%0d dat=%h",
                             i, got_ack[i], wr_log[i], want_ack[i], want_dat[i]);
                end
            end
        end
        // with requester 0 gone, requester 1 must be served next
        seen = 1'b0;
        for (n = 0; n < 10 && !seen; n++) begin
            tick();
            if (o_push) begin
                seen = 1'b1;
                checks++;
                if ({o_ack0, o_ack1, o_dat} !== {2'b01, 8'h22}) begin
                    errors++;
                    $display("FAIL rr_req1_after got ack0=%b ack1=%b dat=%h want 0 1 22", o_ack0, o_ack1, o_dat);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rr_req1_timeout got no push in 10 cycles want push");
        end
        drain();
    endtask

    task automatic test_full();
        int ackn = 0;
        bit seen;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        wr_log.delete();
        mlog.delete();
        pop    = 1'b0;
        i_req1 = 1'b1;
        i_dat1 = 8'h01;
        for (int c = 0; c < 40 && ackn < 4; c++) begin
            tick();
            checks++;
            if ({o_push, o_ack0, o_ack1, o_busy, o_dat} !== {exp_push, exp_ack0, exp_ack1, exp_busy, exp_dat}) begin
                errors++;
                $display("FAIL full_model t=%0t got push=%b ack=%b%b busy=%b dat=%h want %b %b%b %b %h", $time,
                         o_push, o_ack0, o_ack1, o_busy, o_dat, exp_push, exp_ack0, exp_ack1, exp_busy, exp_dat);
            end
            if (o_ack1) begin
                ackn++;
                i_dat1 = DW'(ackn + 1);
            end
        end
        tick();
        checks++;
        if (ackn != 4 || i_full !== 1'b1) begin
            errors++;
            $display("FAIL full_flag got acks=%0d full=%b want 4 1", ackn, i_full);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({o_push, o_ack1, o_busy} !== 3'b000) begin
                errors++;
                $display("FAIL full_stall got push=%b ack1=%b busy=%b want 0 0 0", o_push, o_ack1, o_busy);
            end
        end
        pop = 1'b1;
        tick();
        pop  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (o_ack1) begin
                seen = 1'b1;
                checks++;
                if ({o_push, o_dat} !== {1'b1, 8'h05}) begin
                    errors++;
                    $display("FAIL full_fifth got push=%b dat=%h want 1 05", o_push, o_dat);
                end
            end
        end
        i_req1 = 1'b0;
        tick();
        checks++;
        if (!seen || wr_log.size() != 5) begin
            errors++;
            $display("FAIL full_fifth_written got acked=%0d writes=%0d want 1 5", seen, wr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_log[i] !== DW'(i + 1)) begin
                    errors++;
                    $display("FAIL full_order idx=%0d got %h want %h", i, wr_log[i], DW'(i + 1));
                end
            end
        end
        drain();
    endtask

    task automatic test_full_release();
        int ackn = 0;
        i_req0 = 1'b1;
        i_dat0 = 8'hA0;
        for (int c = 0; c < 40 && ackn < 4; c++) begin
            tick();
            if (o_ack0) begin
                ackn++;
                i_dat0 = 8'hA0 + DW'(ackn);
                if (ackn == 4) i_req0 = 1'b0;
            end
        end
        repeat (3) tick();
        checks++;
        if (i_full !== 1'b1) begin
            errors++;
            $display("FAIL release_fill got full=%b acks=%0d want 1 4", i_full, ackn);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checks++;
        if (i_full !== 1'b0 || o_push !== 1'b0) begin
            errors++;
            $display("FAIL release_full_drop got full=%b push=%b want 0 0", i_full, o_push);
        end
        i_req0 = 1'b1;
        i_dat0 = 8'hB4;
        tick();
        checks++;
        if ({o_push, o_ack0, o_dat} !== {2'b11, 8'hB4}) begin
            errors++;
            $display("FAIL release_grant got push=%b ack0=%b dat=%h want 1 1 b4", o_push, o_ack0, o_dat);
        end
        i_req0 = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        i_req1 = 1'b1;
        i_dat1 = 8'h5A;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = o_push;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_push got no push in 10 cycles want push");
        end
        i_reset = 1'b1;
        tick();
        checks++;
        if ({o_push, o_ack0, o_ack1, o_busy, o_dat} !== {4'b0000, 8'h00} || fq.size() != 0) begin
            errors++;
            $display("FAIL rstmid_idle got push=%b ack=%b%b busy=%b dat=%h size=%0d want zeros size 0",
                     o_push, o_ack0, o_ack1, o_busy, o_dat, fq.size());
        end
        i_reset = 1'b0;
        i_req0  = 1'b1;
        i_dat0  = 8'hC3;
        tick();
        checks++;
        if ({o_push, o_ack0, o_ack1, o_dat} !== {3'b110, 8'hC3}) begin
            errors++;
            $display("FAIL rstmid_req0_first got push=%b ack0=%b ack1=%b dat=%h want 1 1 0 c3",
                     o_push, o_ack0, o_ack1, o_dat);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic prev_push = 1'b0;
        int   acks = 0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        wr_log.delete();
        mlog.delete();
        for (int c = 0; c < 300; c++) begin
            tick();
            checks++;
            if ({o_push, o_ack0, o_ack1, o_busy, o_dat} !== {exp_push, exp_ack0, exp_ack1, exp_busy, exp_dat}) begin
                errors++;
                $display("FAIL b2b_model t=%0t got push=%b ack=%b%b busy=%b dat=%h want %b %b%b %b %h", $time,
                         o_push, o_ack0, o_ack1, o_busy, o_dat, exp_push, exp_ack0, exp_ack1, exp_busy, exp_dat);
            end
            if (o_push) begin
                checks++;
                if (prev_push !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_push_edge t=%0t got prior push=%b want 0", $time, prev_push);
                end
            end
            prev_push = o_push;
            if (o_ack0 || o_ack1) acks++;
            if (o_ack0) begin
                i_req0 = 1'($urandom_range(0, 1));
                i_dat0 = DW'($urandom);
            end else if (!i_req0 && $urandom_range(0, 2) == 0) begin
                i_req0 = 1'b1;
                i_dat0 = DW'($urandom);
            end
            if (o_ack1) begin
                i_req1 = 1'($urandom_range(0, 1));
                i_dat1 = DW'($urandom);
            end else if (!i_req1 && $urandom_range(0, 2) == 0) begin
                i_req1 = 1'b1;
                i_dat1 = DW'($urandom);
            end
            pop = ($urandom_range(0, 3) != 0);
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        repeat (4) tick();
        checks++;
        if (acks < 8 || wr_log.size() != mlog.size()) begin
            errors++;
            $display("FAIL b2b_count got acks=%0d writes=%0d want >=8 and %0d", acks, wr_log.size(), mlog.size());
        end else begin
            for (int i = 0; i < wr_log.size(); i++) begin
                checks++;
                if (wr_log[i] !== mlog[i]) begin
                    errors++;
                    $display("FAIL b2b_data idx=%0d got %h want %h", i, wr_log[i], mlog[i]);
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_full_release();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
